// File: rtl/mfp_uart_pkg.sv
// Shared UART definitions for the mfp_system serial link (receiver and future transmitter).
package mfp_uart_pkg;

  typedef enum logic [2:0] {
    ST_ARM   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Clock cycles per serial bit, rounded to nearest (10 MHz / 115200 -> 87).
  function automatic int clks_per_bit(input int clock_hz, input int baud);
    return (clock_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/mfp_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module mfp_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Double-register the input; reset value matches the idle level of the line.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mfp_uart_receiver.sv
// 8N1 UART receiver with one-entry holding register and sticky error flags.
module mfp_uart_receiver
  import mfp_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  output logic       framing_error,
  input  logic       err_clear
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  // START exits after CLKS_PER_BIT/2 counted cycles, landing mid start bit.
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    C_LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic        w_rxs;
  uart_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_deliver;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ovr;
  logic        r_ferr;

  mfp_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_d     (UART_RX),
    .o_q     (w_rxs)
  );

  // Frame FSM, holding register and sticky flags; set events are written
  // after the clear so a coincident set wins.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state   <= ST_ARM;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_deliver <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ovr     <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_deliver <= 1'b0;

      if (err_clear) begin
        r_ovr  <= 1'b0;
        r_ferr <= 1'b0;
      end

      // A delivered byte lands one edge after the stop sample.
      if (r_deliver) begin
        if (!r_valid || rx_ack) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (rx_ack && r_valid) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_ARM: begin
          // Require a full idle bit time before accepting a start edge.
          if (!w_rxs) begin
            r_cnt <= '0;
          end else if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (!w_rxs) begin
            r_cnt   <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rxs ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == C_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rxs;
            if (r_idx == C_LAST_IDX) begin
              r_state <= ST_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_deliver <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              // Break or bad stop: drop the byte and wait for a clean idle bit.
              r_ferr  <= 1'b1;
              r_state <= ST_ARM;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_ARM;
      endcase
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign overrun       = r_ovr;
  assign framing_error = r_ferr;

endmodule

// File: tb/tb_mfp_uart_receiver.sv
// Directed testbench for mfp_uart_receiver at 16 clocks per bit.
module tb_mfp_uart_receiver;
  import mfp_uart_pkg::*;

  localparam int CPB = 16;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       UART_RX = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       overrun;
  logic       framing_error;
  logic       err_clear = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start = 0;
  int t_rise = -1;
  logic prev_valid = 1'b0;

  mfp_uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .UART_RX       (UART_RX),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ack        (rx_ack),
    .overrun       (overrun),
    .framing_error (framing_error),
    .err_clear     (err_clear)
  );

  always #5 HCLK = ~HCLK;

  // Count rising edges so latencies can be measured in cycles.
  always @(posedge HCLK) cyc = cyc + 1;

  // Record the edge index at which rx_valid rises.
  always @(negedge HCLK) begin
    if (rx_valid && !prev_valid) t_rise = cyc;
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // Drive one 10-bit frame; ack_step selects the frame cycle in which rx_ack is high.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_step);
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge HCLK);
      if (k == 0) t_start = cyc + 1;
      if (k < CPB)            UART_RX = 1'b0;
      else if (k < 9 * CPB)   UART_RX = b[(k / CPB) - 1];
      else                    UART_RX = stop;
      rx_ack = (k == ack_step);
    end
    @(negedge HCLK);
    rx_ack = 1'b0;
  endtask

  task automatic pop();
    rx_ack = 1'b1;
    @(negedge HCLK);
    rx_ack = 1'b0;
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(negedge HCLK);
    err_clear = 1'b0;
  endtask

  initial begin
    // Reset with idle line
    HRESETn = 1'b0;
    UART_RX = 1'b1;
    idle(3);
    check("rst_data",  32'(rx_data), 32'h00);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_ovr",   32'(overrun), 32'd0);
    check("rst_ferr",  32'(framing_error), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(ST_ARM));

    // Line stuck low from reset
    HRESETn = 1'b0;
    UART_RX = 1'b0;
    idle(3);
    HRESETn = 1'b1;
    idle(500);
    check("stuck_valid", 32'(rx_valid), 32'd0);
    check("stuck_ovr",   32'(overrun), 32'd0);
    check("stuck_ferr",  32'(framing_error), 32'd0);
    check("stuck_state", 32'(dut.r_state), 32'(ST_ARM));

    // Basic byte with latency measurement
    UART_RX = 1'b1;
    idle(20);
    t_rise = -1;
    send_frame(8'hA5, 1'b1, -1);
    check("basic_latency", 32'(t_rise - t_start), 32'd155);
    check("basic_data",    32'(rx_data), 32'hA5);
    check("basic_valid",   32'(rx_valid), 32'd1);
    check("basic_ovr",     32'(overrun), 32'd0);
    check("basic_ferr",    32'(framing_error), 32'd0);
    pop();
    check("pop_valid", 32'(rx_valid), 32'd0);
    check("pop_data",  32'(rx_data), 32'hA5);

    // Short glitch on an idle line, then a real frame
    idle(20);
    UART_RX = 1'b0;
    idle(4);
    UART_RX = 1'b1;
    idle(30);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check("glitch_ferr",  32'(framing_error), 32'd0);
    check("glitch_state", 32'(dut.r_state), 32'(ST_IDLE));
    send_frame(8'h3C, 1'b1, -1);
    check("after_glitch_data",  32'(rx_data), 32'h3C);
    check("after_glitch_valid", 32'(rx_valid), 32'd1);
    pop();

    // Overrun: second byte arrives while the first is still held
    idle(5);
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    check("ovr_data",  32'(rx_data), 32'h11);
    check("ovr_flag",  32'(overrun), 32'd1);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    pop();
    check("ovr_pop_valid", 32'(rx_valid), 32'd0);
    send_frame(8'h33, 1'b1, -1);
    check("ovr_third_data",  32'(rx_data), 32'h33);
    check("ovr_third_valid", 32'(rx_valid), 32'd1);
    check("ovr_sticky",      32'(overrun), 32'd1);
    clear_errs();
    check("ovr_cleared", 32'(overrun), 32'd0);
    pop();

    // Pop in the same cycle as the next delivery (frame cycle 155)
    send_frame(8'h11, 1'b1, -1);
    check("same_first_data", 32'(rx_data), 32'h11);
    send_frame(8'h22, 1'b1, 155);
    check("same_data",  32'(rx_data), 32'h22);
    check("same_valid", 32'(rx_valid), 32'd1);
    check("same_ovr",   32'(overrun), 32'd0);
    pop();

    // Framing error: stop bit low, line held low, then recovery
    send_frame(8'h5A, 1'b0, -1);
    idle(40);
    check("ferr_flag",  32'(framing_error), 32'd1);
    check("ferr_valid", 32'(rx_valid), 32'd0);
    check("ferr_state", 32'(dut.r_state), 32'(ST_ARM));
    UART_RX = 1'b1;
    idle(15);
    send_frame(8'h0F, 1'b1, -1);
    check("ferr_recover_data",  32'(rx_data), 32'h0F);
    check("ferr_recover_valid", 32'(rx_valid), 32'd1);
    check("ferr_sticky",        32'(framing_error), 32'd1);
    clear_errs();
    check("ferr_cleared", 32'(framing_error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
